// File: rtl/hamming7_pkg.sv
// Shared definitions for the hamming7 scheduler slice.
// Contents: error-injection mode constants, the 7-bit codeword type and
// the Hamming(7,4) encode function (bit k-1 of a codeword holds position k).
package hamming7_pkg;

    localparam int unsigned CODE_W = 7;

    localparam logic [1:0] ERR_OFF   = 2'd0;
    localparam logic [1:0] ERR_FIXED = 2'd1;
    localparam logic [1:0] ERR_SWEEP = 2'd2;

    typedef logic [CODE_W-1:0] code7_t;

    // Positions 1..7 = p1 p2 d1 p3 d2 d3 d4; nibble bit 0 is d1.
    function automatic code7_t ham7_encode(input logic [3:0] nibble);
        code7_t c;
        c[0] = nibble[0] ^ nibble[1] ^ nibble[3];
        c[1] = nibble[0] ^ nibble[2] ^ nibble[3];
        c[2] = nibble[0];
        c[3] = nibble[1] ^ nibble[2] ^ nibble[3];
        c[4] = nibble[1];
        c[5] = nibble[2];
        c[6] = nibble[3];
        return c;
    endfunction

endpackage

// File: rtl/hamming7_enc.sv
// Combinational Hamming(7,4) encoder with single-bit error injection.
// Ports:
//   nibble_i  in  4  data nibble, bit 0 = d1
//   pos_i     in  3  codeword position to flip (1..7), 0 = no flip
//   code_o    out 7  encoded (and possibly corrupted) codeword
module hamming7_enc
    import hamming7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic [2:0] pos_i,
    output code7_t     code_o
);

    code7_t flip_c;

    // Position k lives in bit k-1, so the flip mask is shifted by pos-1.
    assign flip_c = (pos_i == 3'd0) ? code7_t'(0)
                                    : code7_t'(7'd1 << (pos_i - 3'd1));

    assign code_o = ham7_encode(nibble_i) ^ flip_c;

endmodule

// File: rtl/hamming7_sched.sv
// Two-requester round-robin scheduler in front of one shared Hamming(7,4)
// encoder, with a one-deep registered valid/ready output stage.
// Optional feature macro: HAM7_ERR_INJECT_EN (error injection + sweep counter);
// when undefined the cfg_* inputs are ignored and every word is clean.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   req_valid/ready   per-requester handshake (req_ready is combinational)
//   req_data          nibble i on [4i+3:4i]
//   cfg_err_mode/pos  injection mode (0 off, 1 fixed, 2 sweep, 3 off) and position
//   out_valid/ready   output handshake
//   out_code/src      registered codeword and source requester index
//   out_err_pos       position flipped in the registered word, 0 = clean
module hamming7_sched
    import hamming7_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic [1:0]        cfg_err_mode,
    input  logic [2:0]        cfg_err_pos,
    output logic              out_valid,
    output code7_t            out_code,
    output logic              out_src,
    output logic [2:0]        out_err_pos,
    input  logic              out_ready
);

    logic       last_grant_q;
    logic       out_valid_q;
    code7_t     out_code_q;
    logic       out_src_q;
    logic [2:0] out_err_pos_q;

    logic       grant_idx_c;
    logic       space_c;
    logic       accept_c;
    logic [3:0] nibble_c;
    logic [2:0] err_pos_c;
    code7_t     enc_code_c;

    // Arbitration: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        grant_idx_c = 1'b0;
        if (req_valid[0] && req_valid[1]) begin
            grant_idx_c = ~last_grant_q;
        end else if (req_valid[1]) begin
            grant_idx_c = 1'b1;
        end
        space_c   = ~out_valid_q | out_ready;
        accept_c  = (|req_valid) & space_c & ~reset;
        req_ready = '0;
        if (accept_c) begin
            req_ready[grant_idx_c] = 1'b1;
        end
    end

    assign nibble_c = grant_idx_c ? req_data[7:4] : req_data[3:0];

`ifdef HAM7_ERR_INJECT_EN
    logic [2:0] sweep_q;
    logic [2:0] sweep_d;

    // Error position selection and sweep advance (1..7, wrapping, never 0).
    always_comb begin
        err_pos_c = 3'd0;
        case (cfg_err_mode)
            ERR_FIXED: err_pos_c = cfg_err_pos;
            ERR_SWEEP: err_pos_c = sweep_q;
            default:   err_pos_c = 3'd0;
        endcase
        sweep_d = sweep_q;
        if (accept_c && (cfg_err_mode == ERR_SWEEP)) begin
            sweep_d = (sweep_q == 3'd7) ? 3'd1 : sweep_q + 3'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sweep_q <= 3'd1;
        end else begin
            sweep_q <= sweep_d;
        end
    end
`else
    logic unused_cfg_c;

    assign err_pos_c    = 3'd0;
    assign unused_cfg_c = ^{cfg_err_mode, cfg_err_pos};
`endif

    hamming7_enc u_enc (
        .nibble_i (nibble_c),
        .pos_i    (err_pos_c),
        .code_o   (enc_code_c)
    );

    // Output stage: load on accept, drop valid when popped without a refill.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q  <= 1'b1;
            out_valid_q   <= 1'b0;
            out_code_q    <= '0;
            out_src_q     <= 1'b0;
            out_err_pos_q <= 3'd0;
        end else begin
            if (accept_c) begin
                last_grant_q  <= grant_idx_c;
                out_valid_q   <= 1'b1;
                out_code_q    <= enc_code_c;
                out_src_q     <= grant_idx_c;
                out_err_pos_q <= err_pos_c;
            end else if (out_ready) begin
                out_valid_q   <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_code    = out_code_q;
    assign out_src     = out_src_q;
    assign out_err_pos = out_err_pos_q;

endmodule

// File: tb/tb_hamming7_sched.sv
// Self-checking bench for hamming7_sched: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_hamming7_sched;

    logic       clock;
    logic       reset;
    logic [1:0] req_valid;
    logic [7:0] req_data;
    logic [1:0] req_ready;
    logic [1:0] cfg_err_mode;
    logic [2:0] cfg_err_pos;
    logic       out_valid;
    logic [6:0] out_code;
    logic       out_src;
    logic [2:0] out_err_pos;
    logic       out_ready;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic       m_valid;
    logic [6:0] m_code;
    logic       m_src;
    logic [2:0] m_err;
    logic       m_last;
    int         m_sweep;

    hamming7_sched #(.NREQ(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .cfg_err_mode (cfg_err_mode),
        .cfg_err_pos  (cfg_err_pos),
        .out_valid    (out_valid),
        .out_code     (out_code),
        .out_src      (out_src),
        .out_err_pos  (out_err_pos),
        .out_ready    (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Hamming word built from the textbook rule: data at non-power-of-two
    // positions, parity at position 2^k covers every data position with bit k set.
    function automatic logic [6:0] ref_code(input logic [3:0] n, input logic [2:0] pos);
        int         dpos [4];
        logic [7:1] w;
        logic       p;
        dpos = '{3, 5, 6, 7};
        w = '0;
        for (int i = 0; i < 4; i++) w[dpos[i]] = n[i];
        for (int k = 0; k < 3; k++) begin
            p = 1'b0;
            for (int i = 0; i < 4; i++) if ((dpos[i] >> k) % 2 == 1) p ^= n[i];
            w[1 << k] = p;
        end
        if (pos != 0) w[pos] = ~w[pos];
        return w[7:1];
    endfunction

    function automatic logic [2:0] ref_pos(input logic [1:0] mode, input logic [2:0] fpos, input int sweep);
`ifdef HAM7_ERR_INJECT_EN
        if (mode == 2'd1) return fpos;
        if (mode == 2'd2) return 3'(sweep);
`endif
        return 3'd0;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_code  = '0;
        m_src   = 1'b0;
        m_err   = '0;
        m_last  = 1'b1;
        m_sweep = 1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".code"},  32'(out_code),  32'(m_code));
        check({tag, ".src"},   32'(out_src),   32'(m_src));
        check({tag, ".err"},   32'(out_err_pos), 32'(m_err));
    endtask

    // One clock: drive inputs, check req_ready mid-cycle, advance model, check outputs.
    task automatic cycle(input string tag, input logic [1:0] v, input logic [7:0] d,
                         input logic [1:0] mode, input logic [2:0] pos, input logic ordy);
        logic       space;
        logic       g;
        logic [1:0] exp_rdy;
        logic [3:0] nib;
        req_valid    = v;
        req_data     = d;
        cfg_err_mode = mode;
        cfg_err_pos  = pos;
        out_ready    = ordy;
        @(negedge clock);
        space = !m_valid || ordy;
        if (v == 2'b11) g = !m_last;
        else            g = v[1];
        exp_rdy = (v != 0 && space) ? (2'b01 << g) : 2'b00;
        check({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
        if (exp_rdy != 0) begin
            nib     = g ? d[7:4] : d[3:0];
            m_err   = ref_pos(mode, pos, m_sweep);
            m_code  = ref_code(nib, m_err);
            m_src   = g;
            m_valid = 1'b1;
            m_last  = g;
`ifdef HAM7_ERR_INJECT_EN
            if (mode == 2'd2) m_sweep = (m_sweep % 7) + 1;
`endif
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        @(posedge clock);
        #1;
        check_outputs(tag);
    endtask

    task automatic sync_reset();
        req_valid = 2'b11;
        reset = 1'b1;
        #1;
        check("rst.ready", 32'(req_ready), 32'd0);
        @(posedge clock);
        #1;
        model_reset();
        check_outputs("rst");
        req_valid = 2'b00;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        req_valid    = '0;
        req_data     = '0;
        cfg_err_mode = '0;
        cfg_err_pos  = '0;
        out_ready    = 1'b1;
        model_reset();
        #1;
        check("por.ready", 32'(req_ready), 32'd0);
        check_outputs("por");
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Basic encoding from each requester.
        cycle("enc0", 2'b01, 8'h01, 2'd0, 3'd0, 1'b1);
        check("enc0.const", 32'(out_code), 32'h07);
        cycle("enc1", 2'b10, 8'h80, 2'd0, 3'd0, 1'b1);
        check("enc1.const", 32'(out_code), 32'h4B);
        check("enc1.srcc", 32'(out_src), 32'd1);

        // Fixed-position injection.
        cycle("fix", 2'b01, 8'h01, 2'd1, 3'd3, 1'b1);
`ifdef HAM7_ERR_INJECT_EN
        check("fix.const", 32'(out_code), 32'h03);
        check("fix.errc", 32'(out_err_pos), 32'd3);
`else
        check("fix.const", 32'(out_code), 32'h07);
        check("fix.errc", 32'(out_err_pos), 32'd0);
`endif

        // Sweep over nine zero nibbles.
        for (int i = 0; i < 9; i++) begin
            cycle("sweep", 2'b01, 8'h00, 2'd2, 3'd0, 1'b1);
`ifdef HAM7_ERR_INJECT_EN
            check("sweep.const", 32'(out_code), 32'(1) << (i % 7));
`else
            check("sweep.const", 32'(out_code), 32'd0);
`endif
        end

        // Fairness right after reset: 0,1,0,1,... with no idle cycle.
        sync_reset();
        for (int i = 0; i < 6; i++) begin
            cycle("fair", 2'b11, 8'h5A, 2'd0, 3'd0, 1'b1);
            check("fair.seq", 32'(out_src), 32'(i % 2));
        end

        // Backpressure then simultaneous pop/push.
        for (int i = 0; i < 3; i++) cycle("bp", 2'b11, 8'h3C, 2'd0, 3'd0, 1'b0);
        cycle("bp.pop", 2'b11, 8'h3C, 2'd0, 3'd0, 1'b1);
        check("bp.popvalid", 32'(out_valid), 32'd1);

        // Asynchronous reset while a word is held.
        cycle("pre", 2'b11, 8'hE7, 2'd2, 3'd0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("arst.valid", 32'(out_valid), 32'd0);
        model_reset();
        req_valid = 2'b00;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        cycle("post", 2'b11, 8'hF0, 2'd2, 3'd0, 1'b1);
        check("post.src", 32'(out_src), 32'd0);
`ifdef HAM7_ERR_INJECT_EN
        check("post.sweep", 32'(out_err_pos), 32'd1);
`else
        check("post.sweep", 32'(out_err_pos), 32'd0);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle("rnd", 2'($urandom), 8'($urandom), 2'($urandom),
                  3'($urandom), ($urandom_range(0, 9) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hamming7_sched.md
# hamming7_sched

Round-robin scheduler sharing one Hamming(7,4) encoder between two nibble requesters, with a registered codeword output and a configurable single-bit error-injection position. It sits upstream of the channel model in the hamming7 test environment. It arbitrates source valid/ready handshakes, encodes the granted nibble, optionally flips one codeword bit, and presents the result with a source tag on a valid/ready output port.

## Interface

Parameters:
- NREQ, 2, number of requesters; fixed at 2, since arbitration is a single last-grant bit.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester data valid
- req_data  in  8  nibble i on [4i+3:4i]; bit 0 = d1, bit 3 = d4
- req_ready  out  2  per-requester accept, combinational
- cfg_err_mode  in  2  0 = off, 1 = fixed, 2 = sweep, 3 = reserved (behaves as off)
- cfg_err_pos  in  3  fixed error position 1..7; 0 = none
- out_valid  out  1  codeword valid
- out_code  out  7  bit k-1 = codeword position k
- out_src  out  1  index of the requester that produced the word
- out_err_pos  out  3  position flipped in this word; 0 = clean
- out_ready  in  1  downstream accept

## Operation

- Codeword, positions 1..7: p1 = d1^d2^d4, p2 = d1^d3^d4, d1, p3 = d2^d3^d4, d2, d3, d4.
- Space condition: space = !out_valid | out_ready.
- Arbitration:
  - Only one requester valid: it is granted.
  - Both valid: the one not equal to last_grant is granted.
  - req_ready[i] = grant[i] & space. At most one bit is high.
  - last_grant updates only on an accepted transfer.
- Error position for each accepted word:
  - mode 0 or 3: 0.
  - mode 1: cfg_err_pos.
  - mode 2: sweep counter value.
- Injection: the registered word is the codeword XOR (1 << (pos-1)) when pos ≠ 0.
- Sweep counter:
  - Sequence 1, 2, …, 7, 1, …; it never emits 0.
  - Advances only on an accepted transfer while mode = 2.
  - Holds its value when the mode changes.
- Config inputs are sampled on the accept cycle only. Changes between accepts have no effect on words already registered.

## Timing

- Latency: one cycle. A word accepted at edge N has out_valid high after edge N.
- Output hold: out_code, out_src and out_err_pos stay stable while out_valid & !out_ready.
- Full throughput: when out_ready is held high, one word per cycle.
- Alternation: with both requesters continuously valid, grants alternate 0, 1, 0, 1…
- Simultaneous pop and push (out_valid & out_ready plus a new grant in the same cycle): the register is replaced and out_valid stays 1.
- Reset values:
  - out_valid = 0, out_code = 0, out_src = 0, out_err_pos = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - Sweep counter = 1.
- req_ready is 0 throughout reset.
- Reset asserted mid-transfer discards the registered word. No partial output appears.

## Configuration

- Macro HAM7_ERR_INJECT_EN.
- Defined: injection logic and sweep counter are present, as described above.
- Undefined:
  - cfg_err_mode and cfg_err_pos are ignored.
  - out_err_pos is tied to 0 and every codeword is clean.
  - The sweep counter is not instantiated.
  - Arbitration and timing are otherwise identical.

## Structure

- Package hamming7_pkg holds:
  - Mode constants ERR_OFF, ERR_FIXED, ERR_SWEEP.
  - The codeword typedef code7_t.
  - A function ham7_encode(nibble) returning code7_t.
- One sub-module: hamming7_enc, a combinational encoder plus bit-flip, with inputs nibble and pos and output code7_t. It is shared by both requesters through the grant mux.

## Test plan

- Encode: reset, mode 0, req 0 sends 4'b0001 -> out_code 7'h07, out_src 0, out_err_pos 0, one cycle after accept. Req 1 sends 4'b1000 -> 7'h4B, out_src 1.
- Fixed injection: mode 1, pos 3, nibble 4'b0001 -> out_code 7'h03, out_err_pos 3 (build with macro). Without macro -> 7'h07, out_err_pos 0.
- Sweep: mode 2, 9 accepted words of 4'b0000 -> out_err_pos 1..7, 1, 2 and out_code one-hot 7'h01, 7'h02, …, 7'h40, 7'h01, 7'h02.
- Fairness: both valid continuously for 6 cycles with out_ready high -> out_src 0, 1, 0, 1, 0, 1 with no idle cycles.
- Backpressure: out_ready low for 3 cycles while both requesters are valid -> req_ready 0, output stable. After out_ready rises -> pop and new push in the same cycle, out_valid stays 1.
- Reset mid-stream: reset asserted while out_valid = 1 -> out_valid 0 immediately (async). After release, the first tie grants requester 0 and sweep restarts at 1.
